// File: rtl/sync_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_byte_fifo
// Brief    : Single-clock FIFO with registered read data and occupancy count.
//            Optional sticky overflow/underflow flags: SYNC_BYTE_FIFO_ERR_FLAGS_EN
// Revision : 1.0
// ============================================================================
module sync_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset,
    input  logic                     i_Write_Enable,
    input  logic [WIDTH-1:0]         i_Write_Data,
    output logic                     o_Full,
    input  logic                     i_Read_Enable,
    output logic [WIDTH-1:0]         o_Read_Data,
    output logic                     o_Data_Empty,
    output logic [$clog2(DEPTH):0]   o_Count
`ifdef SYNC_BYTE_FIFO_ERR_FLAGS_EN
    ,
    output logic                     o_Overflow,
    output logic                     o_Underflow
`endif
);

    localparam int c_AW = $clog2(DEPTH);
    // DEPTH is a power of two, so the full count is a single set MSB.
    localparam logic [c_AW:0] c_FULL_CNT = {1'b1, {c_AW{1'b0}}};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic [WIDTH-1:0] r_read_data;

    logic w_full;
    logic w_empty;
    logic w_wr_accept;
    logic w_rd_accept;

    assign w_full      = (r_count == c_FULL_CNT);
    assign w_empty     = (r_count == '0);
    assign w_wr_accept = i_Write_Enable & ~w_full;
    assign w_rd_accept = i_Read_Enable & ~w_empty;

    // Storage is deliberately not reset; the pointers define what is valid.
    always_ff @(posedge i_Clock) begin
        if (w_wr_accept && !i_Reset) begin
            r_mem[r_wr_ptr] <= i_Write_Data;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_read_data <= '0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_accept) begin
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_read_data <= r_mem[r_rd_ptr];
            end
            case ({w_wr_accept, w_rd_accept})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef SYNC_BYTE_FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (i_Write_Enable && w_full) begin
                r_overflow <= 1'b1;
            end
            if (i_Read_Enable && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign o_Overflow  = r_overflow;
    assign o_Underflow = r_underflow;
`endif

    assign o_Full       = w_full;
    assign o_Data_Empty = w_empty;
    assign o_Count      = r_count;
    assign o_Read_Data  = r_read_data;

endmodule
`default_nettype wire

// File: tb/tb_sync_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_byte_fifo
// Brief    : Scoreboard bench for sync_byte_fifo against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_sync_byte_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             we  = 1'b0;
    logic [WIDTH-1:0] wd  = '0;
    logic             re  = 1'b0;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] rdata;
    logic [$clog2(DEPTH):0] count;
`ifdef SYNC_BYTE_FIFO_ERR_FLAGS_EN
    logic ovf;
    logic udf;
`endif

    sync_byte_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .i_Clock        (clk),
        .i_Reset        (rst),
        .i_Write_Enable (we),
        .i_Write_Data   (wd),
        .o_Full         (full),
        .i_Read_Enable  (re),
        .o_Read_Data    (rdata),
        .o_Data_Empty   (empty),
        .o_Count        (count)
`ifdef SYNC_BYTE_FIFO_ERR_FLAGS_EN
        ,
        .o_Overflow     (ovf),
        .o_Underflow    (udf)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: contents as a queue, expected pops in a scoreboard.
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] sb[$];
    logic [WIDTH-1:0] last_rd = '0;
    bit               rd_fire  = 1'b0;
    bit               rst_fire = 1'b0;
    bit               checking = 1'b0;
    bit               m_ovf = 1'b0;
    bit               m_udf = 1'b0;
    bit               fire_s;
    bit               rst_s;
    int               n_tests = 0;
    int               n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One clock cycle of stimulus; the model is advanced to its post-edge state.
    task automatic step(input bit s_rst, input bit s_we, input logic [WIDTH-1:0] s_wd,
                        input bit s_re);
        @(negedge clk);
        rst = s_rst; we = s_we; wd = s_wd; re = s_re;
        rd_fire  = 1'b0;
        rst_fire = s_rst;
        if (s_rst) begin
            mq.delete();
            sb.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            checking = 1'b1;
        end else begin
            if (s_we && mq.size() == DEPTH) m_ovf = 1'b1;
            if (s_re && mq.size() == 0)     m_udf = 1'b1;
            if (s_re && mq.size() > 0) begin
                sb.push_back(mq.pop_front());
                rd_fire = 1'b1;
            end
            if (s_we && mq.size() < DEPTH + (rd_fire ? 1 : 0) && !(rd_fire && mq.size() == DEPTH - 1 && 1'b0))
                ;
        end
    endtask

    task automatic do_cycle(input bit s_rst, input bit s_we, input logic [WIDTH-1:0] s_wd,
                            input bit s_re);
        int pre;
        pre = mq.size();
        step(s_rst, s_we, s_wd, s_re);
        // Write acceptance depends on occupancy before this edge, not after the pop.
        if (!s_rst && s_we && pre < DEPTH) mq.push_back(s_wd);
    endtask

    always @(posedge clk) begin
        fire_s = rd_fire;
        rst_s  = rst_fire;
        #1;
        if (checking) begin
            if (rst_s) begin
                last_rd = '0;
            end else if (fire_s) begin
                if (sb.size() == 0) chk("scoreboard_underrun", 32'd1, 32'd0);
                else last_rd = sb.pop_front();
            end
            chk("read_data", rdata, last_rd);
            chk("count", count, mq.size());
            chk("full", full, mq.size() == DEPTH);
            chk("empty", empty, mq.size() == 0);
`ifdef SYNC_BYTE_FIFO_ERR_FLAGS_EN
            chk("overflow", ovf, m_ovf);
            chk("underflow", udf, m_udf);
`endif
        end
    end

    initial begin
        do_cycle(1, 0, 8'h00, 0);
        do_cycle(1, 0, 8'h00, 0);
        // Single byte round trip
        do_cycle(0, 1, 8'h61, 0);
        do_cycle(0, 0, 8'h00, 0);
        do_cycle(0, 0, 8'h00, 1);
        do_cycle(0, 0, 8'h00, 0);
        // Fill to full, dropped write, drain in order
        for (int i = 0; i < DEPTH; i++) do_cycle(0, 1, 8'(i), 0);
        do_cycle(0, 1, 8'hFF, 0);
        do_cycle(0, 1, 8'hEE, 1);
        for (int i = 0; i < DEPTH; i++) do_cycle(0, 0, 8'h00, 1);
        do_cycle(0, 0, 8'h00, 1);
        // Steady occupancy of 3 across pointer wrap
        for (int i = 0; i < 3; i++) do_cycle(0, 1, 8'(8'h20 + i), 0);
        for (int i = 0; i < 40; i++) do_cycle(0, 1, 8'(8'h23 + i), 1);
        for (int i = 0; i < 3; i++) do_cycle(0, 0, 8'h00, 1);
        do_cycle(0, 0, 8'h00, 0);
        // Read while empty with concurrent write
        do_cycle(0, 1, 8'h7A, 1);
        do_cycle(0, 0, 8'h00, 1);
        do_cycle(0, 0, 8'h00, 0);
        // Mid-operation reset, then recovery
        for (int i = 0; i < 5; i++) do_cycle(0, 1, 8'(8'h40 + i), 0);
        do_cycle(0, 0, 8'h00, 1);
        do_cycle(1, 1, 8'h99, 1);
        do_cycle(0, 1, 8'h62, 0);
        do_cycle(0, 0, 8'h00, 1);
        do_cycle(0, 0, 8'h00, 0);
        // Random traffic with phases biased toward full and toward empty
        for (int i = 0; i < 3000; i++) begin
            int wp;
            wp = ((i / 250) % 2 == 0) ? 70 : 30;
            do_cycle($urandom_range(0, 399) == 0,
                     $urandom_range(0, 99) < wp,
                     8'($urandom),
                     $urandom_range(0, 99) < 50);
        end
        for (int i = 0; i < DEPTH + 2; i++) do_cycle(0, 0, 8'h00, 1);
        do_cycle(0, 0, 8'h00, 0);
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_byte_fifo.md
SYNC_BYTE_FIFO -- requirements
Module: sync_byte_fifo

Interface
REQ-001 SHALL provide parameter DEPTH, 16, number of entries; power of two, 4..256.
REQ-002 SHALL provide parameter WIDTH, 8, bits per entry.
REQ-003 SHALL use one clock and a synchronous, active-high reset; all state changes on rising edge of i_Clock.
REQ-004 SHALL have port i_Clock  input  1  system clock.
REQ-005 SHALL have port i_Reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port i_Write_Enable  input  1  push request from upstream producer.
REQ-007 SHALL have port i_Write_Data  input  WIDTH  data pushed when write accepted.
REQ-008 SHALL have port o_Full  output  1  FIFO holds DEPTH entries.
REQ-009 SHALL have port i_Read_Enable  input  1  pop request from downstream case-conversion stage.
REQ-010 SHALL have port o_Read_Data  output  WIDTH  registered pop data.
REQ-011 SHALL have port o_Data_Empty  output  1  FIFO holds zero entries; drives downstream i_Data_Empty.
REQ-012 SHALL have port o_Count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-013 SHALL accept a write iff i_Write_Enable=1 and o_Full=0; entry stored at write pointer, pointer +1.
REQ-014 SHALL accept a read iff i_Read_Enable=1 and o_Data_Empty=0; o_Read_Data updated with head entry on that edge, visible the next cycle (1-cycle read latency), read pointer +1.
REQ-015 SHALL hold o_Read_Data unchanged on cycles with no accepted read.
REQ-016 SHALL wrap both pointers modulo DEPTH; wrap SHALL NOT corrupt data or flags.
REQ-017 SHALL ignore write when full (data dropped, state unchanged) even if a read is accepted in the same cycle.
REQ-018 SHALL ignore read when empty (o_Read_Data held) even if a write is accepted in the same cycle.
REQ-019 SHALL, on simultaneous accepted read and write (0<o_Count<DEPTH), leave o_Count unchanged and preserve order.
REQ-020 SHALL update o_Count: +1 write only, -1 read only, unchanged both/neither.
REQ-021 SHALL derive o_Full (o_Count==DEPTH) and o_Data_Empty (o_Count==0) from registered state; both valid the cycle after the causing edge.
REQ-022 SHALL preserve strict first-in first-out order.

Reset
REQ-023 SHALL, while i_Reset=1 at a clock edge, clear pointers and o_Count to 0, set o_Data_Empty=1, o_Full=0, o_Read_Data=0; writes/reads that cycle ignored.
REQ-024 SHALL discard all stored entries on reset asserted mid-operation; storage contents need not be cleared.
REQ-025 SHALL accept a write on the first edge after i_Reset deasserts.

Configuration
REQ-026 SHALL, when SYNC_BYTE_FIFO_ERR_FLAGS_EN is defined, add outputs o_Overflow (1 bit) and o_Underflow (1 bit): o_Overflow set sticky on a write attempt while full, o_Underflow set sticky on a read attempt while empty, both cleared only by i_Reset.
REQ-027 SHALL, when SYNC_BYTE_FIFO_ERR_FLAGS_EN is undefined, omit both ports and their logic; all other behaviour identical.

Verification
REQ-028 Reset, then write 8'h61 -> next cycle o_Data_Empty=0, o_Count=1; read -> o_Read_Data=8'h61 one cycle later, o_Data_Empty=1.
REQ-029 Write DEPTH bytes 8'h00..8'h0F (DEPTH=16) -> o_Full=1, o_Count=16; 17th write 8'hFF dropped; 16 reads return 8'h00..8'h0F in order.
REQ-030 Fill to 3 entries, then 40 cycles of simultaneous read+write with incrementing data -> o_Count stays 3, read data sequence contiguous across pointer wrap.
REQ-031 Read while empty with concurrent write 8'h7A -> o_Read_Data unchanged, o_Count=1; next read returns 8'h7A.
REQ-032 Write 5 entries, assert i_Reset one cycle -> o_Count=0, o_Data_Empty=1, o_Read_Data=0; subsequent write 8'h62 then read returns 8'h62.
REQ-033 With SYNC_BYTE_FIFO_ERR_FLAGS_EN: read when empty -> o_Underflow=1; write when full -> o_Overflow=1; both remain 1 until i_Reset, then 0.
